sseg_scroller: RTL and testbench

SSEG_SCROLLER -- requirements
Module: sseg_scroller

---
 rtl/sseg_pkg.sv | 41 ++++
 rtl/sseg_decode.sv | 22 ++
 rtl/sseg_scroller.sv | 107 ++++++++++
 tb/tb_sseg_scroller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared character codes, segment constants and the {dp,char} buffer entry type
// for the scrolling seven-segment message display.
package sseg_pkg;

   localparam logic [4:0] CHAR_BLANK = 5'd16;
   localparam logic [4:0] CHAR_DASH  = 5'd17;
   localparam logic [7:0] SEG_OFF_N  = 8'hFF;
   localparam logic [7:0] SEG_DASH_N = 8'hBF;

   typedef struct packed {
      logic       dp;
      logic [4:0] code;
   } sseg_entry_t;

   localparam sseg_entry_t ENTRY_BLANK = '{dp: 1'b0, code: CHAR_BLANK};

   // Active-low {dp,g,f,e,d,c,b,a} pattern for a hex nibble, dp left dark.
   function automatic logic [7:0] hex_seg_n(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational decoder from a {dp,char} buffer entry to an active-low
// seven-segment pattern; one instance per displayed digit.
module sseg_decode
   import sseg_pkg::*;
(
   input  sseg_entry_t entry,
   output logic [7:0]  seg_n
);

   always_comb begin
      seg_n = SEG_OFF_N;
      if (entry.code < CHAR_BLANK) begin
         seg_n = hex_seg_n(entry.code[3:0]);
      end else if (entry.code == CHAR_DASH) begin
         seg_n = SEG_DASH_N;
      end
      if (entry.dp) begin
         seg_n[7] = 1'b0;
      end
   end

endmodule

// File: rtl/sseg_scroller.sv
// Scrolls a small writable character buffer across a four-digit seven-segment
// display, stepping once every 2^TICK_N enabled clocks in either direction.
module sseg_scroller
   import sseg_pkg::*;
#(
   parameter int TICK_N  = 26,
   parameter int MSG_LEN = 10
)
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_dir,
   input  logic       i_wr,
   input  logic [3:0] i_waddr,
   input  logic [4:0] i_wchar,
   input  logic       i_wdp,
   output logic [7:0] o_digit_n [3:0],
   output logic [3:0] o_pos,
   output logic       o_tick
);

   localparam logic [3:0] LAST_POS = 4'(MSG_LEN - 1);
   localparam logic [4:0] LEN5     = 5'(MSG_LEN);

   logic [TICK_N-1:0] tick_cnt;
   logic [3:0]        pos_q;
   logic [3:0]        pos_next;
   logic              write_ok;
   sseg_entry_t       msg_buf [MSG_LEN];
   logic [7:0]        seg_n [3:0];

   // The step fires in the cycle the counter is about to wrap, so it can never
   // be seen while scrolling is frozen.
   assign o_tick   = i_en & (&tick_cnt);
   assign o_pos    = pos_q;
   assign write_ok = i_wr && ({1'b0, i_waddr} < LEN5);

   function automatic logic [3:0] wrap_idx(input logic [3:0] p, input logic [1:0] off);
      logic [4:0] sum;
      sum = {1'b0, p} + {3'b000, off};
      if (sum >= LEN5) begin
         sum = sum - LEN5;
      end
      return sum[3:0];
   endfunction

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tick_cnt <= '0;
      end else if (i_en) begin
         tick_cnt <= tick_cnt + TICK_N'(1);
      end
   end

   always_comb begin
      pos_next = pos_q;
      if (i_dir) begin
         pos_next = (pos_q == 4'd0) ? LAST_POS : pos_q - 4'd1;
      end else begin
         pos_next = (pos_q == LAST_POS) ? 4'd0 : pos_q + 4'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pos_q <= 4'd0;
      end else if (o_tick) begin
         pos_q <= pos_next;
      end
   end

   // Out-of-range addresses are dropped so the buffer is never written past its end.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            msg_buf[i] <= ENTRY_BLANK;
         end
      end else if (write_ok) begin
         msg_buf[i_waddr] <= '{dp: i_wdp, code: i_wchar};
      end
   end

   // Digit k shows entry (pos+3-k) mod MSG_LEN; digit 3 is the leftmost.
   for (genvar k = 0; k < 4; k++) begin : g_digit
      localparam logic [1:0] OFF = 2'(3 - k);
      logic [3:0] idx;
      assign idx = wrap_idx(pos_q, OFF);
      sseg_decode u_decode (
         .entry (msg_buf[idx]),
         .seg_n (seg_n[k])
      );
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < 4; k++) begin
            o_digit_n[k] <= SEG_OFF_N;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            o_digit_n[k] <= seg_n[k];
         end
      end
   end

endmodule

// File: tb/tb_sseg_scroller.sv
// Randomized self-checking bench for sseg_scroller against a behavioural
// model of the message buffer, scroll position and digit rendering.
module tb_sseg_scroller;

   localparam int TICK_N  = 2;
   localparam int MSG_LEN = 10;
   localparam int PERIOD  = 1 << TICK_N;

   localparam logic [7:0] HEX_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic       i_clk;
   logic       i_reset;
   logic       i_en;
   logic       i_dir;
   logic       i_wr;
   logic [3:0] i_waddr;
   logic [4:0] i_wchar;
   logic       i_wdp;
   logic [7:0] digit_n [3:0];
   logic [3:0] o_pos;
   logic       o_tick;

   int         total;
   int         bad;
   int         m_cnt;
   int         m_pos;
   logic [5:0] m_buf [MSG_LEN];
   logic [7:0] m_disp [4];
   logic       tick_seen;
   int         tick_at;

   sseg_scroller #(.TICK_N(TICK_N), .MSG_LEN(MSG_LEN)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_en      (i_en),
      .i_dir     (i_dir),
      .i_wr      (i_wr),
      .i_waddr   (i_waddr),
      .i_wchar   (i_wchar),
      .i_wdp     (i_wdp),
      .o_digit_n (digit_n),
      .o_pos     (o_pos),
      .o_tick    (o_tick)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [7:0] expSeg(input logic [5:0] e);
      logic [7:0] r;
      if (e[4:0] < 5'd16)       r = HEX_TAB[e[3:0]];
      else if (e[4:0] == 5'd17) r = 8'hBF;
      else                      r = 8'hFF;
      if (e[5]) r[7] = 1'b0;
      return r;
   endfunction

   task automatic modelReset();
      m_cnt = 0;
      m_pos = 0;
      for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 6'h10;
      for (int k = 0; k < 4; k++) m_disp[k] = 8'hFF;
   endtask

   task automatic checkDisplay(input string where);
      checkOutput({where, "_pos"}, 32'(o_pos), 32'(m_pos));
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("%s_digit%0d", where, k), 32'(digit_n[k]), 32'(m_disp[k]));
   endtask

   // Called at posedge+1; drives one cycle of inputs and checks before and after the edge.
   task automatic applyStimulus(input logic en, input logic dir, input logic wr,
                                input logic [3:0] waddr, input logic [4:0] wchar, input logic wdp);
      logic exp_tick;
      i_en = en; i_dir = dir; i_wr = wr; i_waddr = waddr; i_wchar = wchar; i_wdp = wdp;
      #1;
      exp_tick = en && (m_cnt == PERIOD - 1);
      checkOutput("tick", 32'(o_tick), 32'(exp_tick));
      tick_seen = o_tick;
      @(posedge i_clk);
      for (int k = 0; k < 4; k++) m_disp[k] = expSeg(m_buf[(m_pos + 3 - k) % MSG_LEN]);
      if (exp_tick) m_pos = dir ? (m_pos + MSG_LEN - 1) % MSG_LEN : (m_pos + 1) % MSG_LEN;
      if (wr && int'(waddr) < MSG_LEN) m_buf[waddr] = {wdp, wchar};
      if (en) m_cnt = (m_cnt + 1) % PERIOD;
      #1;
      checkDisplay("cyc");
   endtask

   initial begin
      total = 0; bad = 0; tick_seen = 1'b0;
      i_reset = 1'b0; i_en = 1'b0; i_dir = 1'b0; i_wr = 1'b0;
      i_waddr = 4'd0; i_wchar = 5'd0; i_wdp = 1'b0;
      modelReset();
      #1 i_reset = 1'b1;
      #1;
      checkDisplay("reset");
      checkOutput("reset_tick", 32'(o_tick), 32'd0);
      @(negedge i_clk) i_reset = 1'b0;
      @(posedge i_clk); #1;

      // Write 1,2,3,4 to entries 0..3 while frozen.
      for (int a = 0; a < 4; a++) applyStimulus(1'b0, 1'b0, 1'b1, 4'(a), 5'(a + 1), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("wr_d3", 32'(digit_n[3]), 32'h F9);
      checkOutput("wr_d0", 32'(digit_n[0]), 32'h 99);

      // Left scroll: first step on the 4th enabled clock.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("left_pos", 32'(o_pos), 32'd1);
      checkOutput("left_d3", 32'(digit_n[3]), 32'h A4);
      checkOutput("left_d0", 32'(digit_n[0]), 32'h FF);
      for (int i = 5; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("wrap_pos", 32'(o_pos), 32'd0);

      // Right scroll from position 0 wraps to the last entry.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("right_pos", 32'(o_pos), 32'd9);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("right_d3", 32'(digit_n[3]), 32'h FF);
      checkOutput("right_d0", 32'(digit_n[0]), 32'h B0);

      // Out-of-range write, then a dash+dp write landing on a step.
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd12, 5'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd1, 5'd17, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("dash_pos", 32'(o_pos), 32'd0);
      checkOutput("dash_d2", 32'(digit_n[2]), 32'h 3F);
      checkOutput("dash_d3", 32'(digit_n[3]), 32'h F9);

      // Pause for 7 cycles mid-period; the step arrives 7 clocks late.
      tick_at = -1;
      for (int i = 0; i < 20 && tick_at < 0; i++) begin
         applyStimulus((i < 2 || i > 8), 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
         if (tick_seen) tick_at = i;
      end
      checkOutput("pause_tick_at", 32'(tick_at), 32'd10);

      // Random traffic: enable, direction and writes (some out of range).
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset during a write, checked before any clock edge.
      i_en = 1'b1; i_wr = 1'b1; i_waddr = 4'd0; i_wchar = 5'd5; i_wdp = 1'b1;
      #1 i_reset = 1'b1;
      #1;
      modelReset();
      checkDisplay("midreset");
      checkOutput("midreset_tick", 32'(o_tick), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk) begin i_reset = 1'b0; i_wr = 1'b0; i_en = 1'b0; end
      @(posedge i_clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      checkOutput("postreset_d3", 32'(digit_n[3]), 32'h FF);
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 1) == 0,
                       4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
